tnn_core: RTL
=============

# tnn_core

Parametrised ternary-weight MLP inference engine: the successor to the fixed three-layer neural core, generalised to NUM_LAYERS fully-connected layers of VEC_WIDTH binary activations. It accepts one binary input vector per inference over a valid/ready handshake and streams one weight row plus one bias per neuron from external memory. A ping-pong activation buffer lets consecutive layers run back-to-back with no bubble. It emits the argmax class and its score over a valid/ready handshake, between the window-slider front end and the system controller.

## Interface
- VEC_WIDTH, 64: activations per layer; input width and hidden-layer neuron count
- NUM_LAYERS, 3: total layers, ≥2; layers 0..NUM_LAYERS-2 are hidden, the last is the classifier
- NUM_CLASSES, 10: classifier neurons, 2..VEC_WIDTH
- BIAS_WIDTH, 4: signed two's-complement bias width
- ROWS, (NUM_LAYERS-1)*VEC_WIDTH+NUM_CLASSES: derived, total weight rows
- ADDR_W, $clog2(ROWS): derived
- SCORE_W, $clog2(VEC_WIDTH+2**(BIAS_WIDTH-1)+1)+1: derived, signed score width

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  core can accept a vector
- in_vec  in  VEC_WIDTH  binary input; bit 1 = +1, bit 0 = -1
- weight_ren  out  1  weight/bias read enable
- weight_addr  out  ADDR_W  row index, shared by the weight and bias memories
- weight_data  in  2*VEC_WIDTH  row data, 1-cycle read latency; bits [2i+1:2i] hold input i
- bias_data  in  BIAS_WIDTH  bias, same address and latency as the weights
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_class  out  $clog2(NUM_CLASSES)  argmax index
- out_score  out  SCORE_W  signed winning score

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, load in_vec into activation buffer A, clear the neuron counter, go to RUN.
- RUN, issue side: each cycle drives weight_ren=1 and weight_addr=n, for n = 0..ROWS-1 contiguous.
- RUN, consume side: weight/bias data for row n arrives the following cycle.
- Ternary weight codes: 2'b01=+1, 2'b11=-1, 2'b00 and 2'b10 = 0.
- Neuron score = Σ w_i·x_i + sign-extended bias, computed in SCORE_W signed. This arithmetic cannot overflow.
- Hidden neuron: activation bit = (score >= 0). The bit is written to the inactive buffer at index (n mod VEC_WIDTH).
- Buffer swap: roles swap after the last neuron of each hidden layer. The next layer's first row arrives exactly one cycle later and reads the new buffer.
- Classifier neuron: running argmax. It updates only on a strictly greater score, so ties resolve to the lowest index.
- After the classifier row ROWS-1 is consumed: register out_class/out_score, go to DONE.
- DONE: out_valid=1, with out_class and out_score stable. On out_ready, go to IDLE.
- rst at any time, including mid-RUN: state→IDLE, counters and argmax cleared, buffers need not clear.

## Timing
- Reset values: in_ready=1, weight_ren=0, weight_addr=0, out_valid=0, out_class=0, out_score=0.
- Cycle 0: input handshake. Cycles 1..ROWS: weight_ren=1 with addresses 0..ROWS-1.
- Data consumed in cycles 2..ROWS+1. out_valid rises at cycle ROWS+2.
- Throughput: one neuron per cycle, no bubble at layer boundaries.
- in_ready=0 throughout RUN and DONE; no overlap of inferences.
- Handshake completing in cycle t: in_ready=1 at t+1. A back-to-back input is accepted at t+1.
- weight_ren=0 outside RUN, and weight_addr holds its last value.

## Structure
- tnn_core_pkg holds:
  - the state enum
  - ternary code constants (TERN_POS, TERN_NEG)
  - the function computing SCORE_W from the parameters
- Sub-module tnn_dot: combinational ternary dot product plus bias (weight row, activation vector, bias → signed score). It is registered by tnn_core.

## Test plan
All scenarios use VEC_WIDTH=8, NUM_LAYERS=2, NUM_CLASSES=4, BIAS_WIDTH=4, ROWS=12.
- Reset: hold rst 3 cycles → all outputs at reset values. After release, in_ready=1 and weight_ren=0.
- All weights 01, biases 0, in_vec=8'hFF → addresses 0..11 in cycles 1..12; out_valid at cycle 14; out_class=0 (tie), out_score=8.
- Hidden weights all 01; class 2 row all 01, other class rows all 11; biases 0; in_vec=8'h0F → hidden scores 0, activations all 1; out_class=2, out_score=8.
- Threshold: hidden row 0 sums to +8 with bias -8 → activation 1. Row 1 sums to 0 with bias -1 → activation 0. Check via classifier rows weighting only those inputs: score equals +1 with bias 0, i.e. (+1)+(-1)+(+1) for a crafted pattern.
- Backpressure: out_ready low 5 cycles → out_valid, out_class and out_score stable, in_ready=0. Then out_ready=1 → in_ready=1 next cycle, and a new vector is accepted.
- rst asserted at cycle 6 → weight_ren=0 and in_ready=1 next cycle. A fresh inference then reproduces the scenario 2 result exactly.

Source files
------------

// File: rtl/tnn_core_pkg.sv
// tnn_core shared types and constants.
// Ternary codes, FSM states and score sizing.
package tnn_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] TERN_POS = 2'b01;
  localparam logic [1:0] TERN_NEG = 2'b11;

  function automatic int score_width(
    input int vec_width,
    input int bias_width
  );
    return $clog2(vec_width + 2**(bias_width-1) + 1) + 1;
  endfunction

endpackage

// File: rtl/tnn_dot.sv
// Combinational ternary dot product plus bias.
// Codes 00/10 contribute nothing.
module tnn_dot
  import tnn_core_pkg::*;
#(
  parameter int VEC_WIDTH  = 64,
  parameter int BIAS_WIDTH = 4,
  parameter int SCORE_W    = 8
) (
  input  logic [2*VEC_WIDTH-1:0] weights,
  input  logic [VEC_WIDTH-1:0]   acts,
  input  logic [BIAS_WIDTH-1:0]  bias,
  output logic [SCORE_W-1:0]     score
);

  localparam logic signed [SCORE_W-1:0] ONE = 1;

  logic signed [SCORE_W-1:0] acc;

  always_comb begin
    acc = SCORE_W'($signed(bias));
    for (int i = 0; i < VEC_WIDTH; i++) begin
      if (weights[2*i +: 2] == TERN_POS) begin
        acc = acts[i] ? acc + ONE : acc - ONE;
      end else if (weights[2*i +: 2] == TERN_NEG) begin
        acc = acts[i] ? acc - ONE : acc + ONE;
      end
    end
  end

  assign score = acc;

endmodule

// File: rtl/tnn_core.sv
// Ternary-weight MLP inference engine.
// One neuron per cycle, ping-pong activations.
module tnn_core
  import tnn_core_pkg::*;
#(
  parameter int VEC_WIDTH   = 64,
  parameter int NUM_LAYERS  = 3,
  parameter int NUM_CLASSES = 10,
  parameter int BIAS_WIDTH  = 4,
  localparam int ROWS =
    (NUM_LAYERS-1)*VEC_WIDTH + NUM_CLASSES,
  localparam int ADDR_W  = $clog2(ROWS),
  localparam int SCORE_W =
    score_width(VEC_WIDTH, BIAS_WIDTH),
  localparam int CLS_W   = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VEC_WIDTH-1:0]   in_vec,
  output logic                   weight_ren,
  output logic [ADDR_W-1:0]      weight_addr,
  input  logic [2*VEC_WIDTH-1:0] weight_data,
  input  logic [BIAS_WIDTH-1:0]  bias_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLS_W-1:0]       out_class,
  output logic [SCORE_W-1:0]     out_score
);

  localparam int HROWS = (NUM_LAYERS-1)*VEC_WIDTH;
  localparam int IDX_W = $clog2(VEC_WIDTH);

  state_e                    state;
  logic [VEC_WIDTH-1:0]      buf_a;
  logic [VEC_WIDTH-1:0]      buf_b;
  logic                      sel;
  logic [VEC_WIDTH-1:0]      act;
  logic                      rd_valid;
  logic [ADDR_W-1:0]         rd_row;
  logic [IDX_W-1:0]          col;
  logic [CLS_W-1:0]          cls;
  logic signed [SCORE_W-1:0] score;
  logic signed [SCORE_W-1:0] best_score;
  logic [CLS_W-1:0]          best_class;
  logic                      hidden;
  logic                      last_row;
  logic                      last_col;
  logic                      take;
  logic                      accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // sel=0: buffer A feeds the current layer
  assign act      = sel ? buf_b : buf_a;
  assign hidden   = rd_row < ADDR_W'(HROWS);
  assign last_row = rd_row == ADDR_W'(ROWS-1);
  assign last_col = col == IDX_W'(VEC_WIDTH-1);
  assign take     = (cls == '0) ||
                    (score > best_score);

  tnn_dot #(
    .VEC_WIDTH (VEC_WIDTH),
    .BIAS_WIDTH(BIAS_WIDTH),
    .SCORE_W   (SCORE_W)
  ) u_dot (
    .weights(weight_data),
    .acts   (act),
    .bias   (bias_data),
    .score  (score)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_a <= in_vec;
    end else if (state == RUN && rd_valid
                 && hidden) begin
      if (sel) begin
        buf_a[col] <= (score >= 0);
      end else begin
        buf_b[col] <= (score >= 0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      weight_ren  <= 1'b0;
      weight_addr <= '0;
      rd_valid    <= 1'b0;
      rd_row      <= '0;
      col         <= '0;
      cls         <= '0;
      sel         <= 1'b0;
      best_score  <= '0;
      best_class  <= '0;
      out_class   <= '0;
      out_score   <= '0;
    end else begin
      rd_valid <= weight_ren;
      rd_row   <= weight_addr;
      unique case (state)
        IDLE: begin
          if (accept) begin
            sel         <= 1'b0;
            weight_ren  <= 1'b1;
            weight_addr <= '0;
            col         <= '0;
            cls         <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (weight_ren) begin
            if (weight_addr == ADDR_W'(ROWS-1)) begin
              weight_ren <= 1'b0;
            end else begin
              weight_addr <= weight_addr + 1'b1;
            end
          end
          if (rd_valid) begin
            if (hidden) begin
              col <= last_col ? '0 : col + 1'b1;
              if (last_col) begin
                sel <= ~sel;
              end
            end else begin
              cls <= cls + 1'b1;
              if (take) begin
                best_score <= score;
                best_class <= cls;
              end
              if (last_row) begin
                out_class <= take ? cls : best_class;
                out_score <= take ? score : best_score;
                state     <= DONE;
              end
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
